// File: rtl/lc3_control.sv
// rtl/lc3_control.sv - LC-3 Moore sequencer: fetch/decode/execute, memory wait states, pause handshake
module lc3_control #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_run,
  input  logic       i_continue,
  input  logic [3:0] i_opcode,
  input  logic       i_ir_5,
  input  logic       i_ben,
  output logic       o_ld_mar,
  output logic       o_ld_mdr,
  output logic       o_ld_ir,
  output logic       o_ld_ben,
  output logic       o_ld_cc,
  output logic       o_ld_reg,
  output logic       o_ld_pc,
  output logic       o_ld_led,
  output logic       o_gate_pc,
  output logic       o_gate_mdr,
  output logic       o_gate_alu,
  output logic       o_gate_marmux,
  output logic [1:0] o_pcmux,
  output logic [1:0] o_addr2mux,
  output logic       o_addr1mux,
  output logic       o_sr1mux,
  output logic       o_sr2mux,
  output logic       o_drmux,
  output logic [1:0] o_aluk,
  output logic       o_mio_en,
  output logic       o_mem_rd,
  output logic       o_mem_wr
);

  typedef enum logic [4:0] {
    S_HALTED, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
    S_ADD, S_AND, S_NOT, S_BR, S_BR_TAKEN, S_JMP,
    S_JSR1, S_JSR2, S_LDR1, S_LDR2, S_LDR3,
    S_STR1, S_STR2, S_STR3, S_PAUSE1, S_PAUSE2
  } state_t;

  localparam logic [2:0] W_LAST = 3'(MEM_WAIT - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] r_wait_cnt;
  logic [2:0] w_wait_cnt_next;
  logic       w_in_wait;
  logic       w_wait_done;

  assign w_in_wait   = (r_state == S_FETCH2) || (r_state == S_LDR2) || (r_state == S_STR3);
  assign w_wait_done = (r_wait_cnt == W_LAST);

  // Every wait state exits to a non-wait state, so clearing on exit doubles as clearing on entry.
  assign w_wait_cnt_next = (w_in_wait && !w_wait_done) ? r_wait_cnt + 3'd1 : 3'd0;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_HALTED;
      r_wait_cnt <= 3'd0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_cnt_next;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_HALTED:   if (i_run) w_next_state = S_FETCH1;
      S_FETCH1:   w_next_state = S_FETCH2;
      S_FETCH2:   if (w_wait_done) w_next_state = S_FETCH3;
      S_FETCH3:   w_next_state = S_DECODE;
      S_DECODE: begin
        case (i_opcode)
          4'b0001: w_next_state = S_ADD;
          4'b0101: w_next_state = S_AND;
          4'b1001: w_next_state = S_NOT;
          4'b0000: w_next_state = S_BR;
          4'b1100: w_next_state = S_JMP;
          4'b0100: w_next_state = S_JSR1;
          4'b0110: w_next_state = S_LDR1;
          4'b0111: w_next_state = S_STR1;
          4'b1101: w_next_state = S_PAUSE1;
          default: w_next_state = S_FETCH1;
        endcase
      end
      S_BR:       w_next_state = i_ben ? S_BR_TAKEN : S_FETCH1;
      S_JSR1:     w_next_state = S_JSR2;
      S_LDR1:     w_next_state = S_LDR2;
      S_LDR2:     if (w_wait_done) w_next_state = S_LDR3;
      S_STR1:     w_next_state = S_STR2;
      S_STR2:     w_next_state = S_STR3;
      S_STR3:     if (w_wait_done) w_next_state = S_FETCH1;
      S_PAUSE1:   if (i_continue) w_next_state = S_PAUSE2;
      S_PAUSE2:   if (!i_continue) w_next_state = S_FETCH1;
      default:    w_next_state = S_FETCH1;
    endcase
  end

  always_comb begin
    o_ld_mar      = 1'b0;
    o_ld_mdr      = 1'b0;
    o_ld_ir       = 1'b0;
    o_ld_ben      = 1'b0;
    o_ld_cc       = 1'b0;
    o_ld_reg      = 1'b0;
    o_ld_pc       = 1'b0;
    o_ld_led      = 1'b0;
    o_gate_pc     = 1'b0;
    o_gate_mdr    = 1'b0;
    o_gate_alu    = 1'b0;
    o_gate_marmux = 1'b0;
    o_pcmux       = 2'b00;
    o_addr2mux    = 2'b00;
    o_addr1mux    = 1'b0;
    o_sr1mux      = 1'b0;
    o_sr2mux      = 1'b0;
    o_drmux       = 1'b0;
    o_aluk        = 2'b00;
    o_mio_en      = 1'b0;
    o_mem_rd      = 1'b0;
    o_mem_wr      = 1'b0;
    case (r_state)
      S_FETCH1: begin
        o_gate_pc = 1'b1;
        o_ld_mar  = 1'b1;
        o_ld_pc   = 1'b1;
      end
      S_FETCH2, S_LDR2: begin
        o_mem_rd = 1'b1;
        o_mio_en = 1'b1;
        o_ld_mdr = w_wait_done;
      end
      S_FETCH3: begin
        o_gate_mdr = 1'b1;
        o_ld_ir    = 1'b1;
      end
      S_DECODE: o_ld_ben = 1'b1;
      S_ADD, S_AND: begin
        o_sr1mux   = 1'b1;
        o_sr2mux   = i_ir_5;
        o_aluk     = (r_state == S_AND) ? 2'b01 : 2'b00;
        o_gate_alu = 1'b1;
        o_ld_reg   = 1'b1;
        o_ld_cc    = 1'b1;
      end
      S_NOT: begin
        o_sr1mux   = 1'b1;
        o_aluk     = 2'b10;
        o_gate_alu = 1'b1;
        o_ld_reg   = 1'b1;
        o_ld_cc    = 1'b1;
      end
      S_BR_TAKEN: begin
        o_addr2mux = 2'b10;
        o_pcmux    = 2'b01;
        o_ld_pc    = 1'b1;
      end
      S_JMP: begin
        o_sr1mux   = 1'b1;
        o_aluk     = 2'b11;
        o_gate_alu = 1'b1;
        o_pcmux    = 2'b10;
        o_ld_pc    = 1'b1;
      end
      S_JSR1: begin
        o_gate_pc = 1'b1;
        o_drmux   = 1'b1;
        o_ld_reg  = 1'b1;
      end
      S_JSR2: begin
        o_addr2mux = 2'b11;
        o_pcmux    = 2'b01;
        o_ld_pc    = 1'b1;
      end
      S_LDR1, S_STR1: begin
        o_sr1mux      = 1'b1;
        o_addr1mux    = 1'b1;
        o_addr2mux    = 2'b01;
        o_gate_marmux = 1'b1;
        o_ld_mar      = 1'b1;
      end
      S_LDR3: begin
        o_gate_mdr = 1'b1;
        o_ld_reg   = 1'b1;
        o_ld_cc    = 1'b1;
      end
      // Store data comes from SR (IR[11:9]) passed through the ALU onto the bus.
      S_STR2: begin
        o_aluk     = 2'b11;
        o_gate_alu = 1'b1;
        o_ld_mdr   = 1'b1;
      end
      S_STR3:   o_mem_wr = 1'b1;
      S_PAUSE1: o_ld_led = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc3_control.sv
// tb/tb_lc3_control.sv - directed bench for lc3_control at MEM_WAIT 2 and 3
module tb_lc3_control;

  localparam logic [24:0] LD_MAR   = 25'd1 << 24;
  localparam logic [24:0] LD_MDR   = 25'd1 << 23;
  localparam logic [24:0] LD_IR    = 25'd1 << 22;
  localparam logic [24:0] LD_BEN   = 25'd1 << 21;
  localparam logic [24:0] LD_CC    = 25'd1 << 20;
  localparam logic [24:0] LD_REG   = 25'd1 << 19;
  localparam logic [24:0] LD_PC    = 25'd1 << 18;
  localparam logic [24:0] LD_LED   = 25'd1 << 17;
  localparam logic [24:0] G_PC     = 25'd1 << 16;
  localparam logic [24:0] G_MDR    = 25'd1 << 15;
  localparam logic [24:0] G_ALU    = 25'd1 << 14;
  localparam logic [24:0] G_MARMUX = 25'd1 << 13;
  localparam logic [24:0] P_ADDER  = 25'd1 << 11;
  localparam logic [24:0] P_BUS    = 25'd2 << 11;
  localparam logic [24:0] A2_6     = 25'd1 << 9;
  localparam logic [24:0] A2_9     = 25'd2 << 9;
  localparam logic [24:0] A2_11    = 25'd3 << 9;
  localparam logic [24:0] A1_SR1   = 25'd1 << 8;
  localparam logic [24:0] SR1_86   = 25'd1 << 7;
  localparam logic [24:0] SR2_IMM  = 25'd1 << 6;
  localparam logic [24:0] DR_R7    = 25'd1 << 5;
  localparam logic [24:0] K_AND    = 25'd1 << 3;
  localparam logic [24:0] K_NOT    = 25'd2 << 3;
  localparam logic [24:0] K_PASS   = 25'd3 << 3;
  localparam logic [24:0] MIO      = 25'd1 << 2;
  localparam logic [24:0] MRD      = 25'd1 << 1;
  localparam logic [24:0] MWR      = 25'd1;

  localparam logic [24:0] E_NONE    = 25'd0;
  localparam logic [24:0] E_FETCH1  = G_PC | LD_MAR | LD_PC;
  localparam logic [24:0] E_RD      = MRD | MIO;
  localparam logic [24:0] E_RD_LAST = MRD | MIO | LD_MDR;
  localparam logic [24:0] E_FETCH3  = G_MDR | LD_IR;
  localparam logic [24:0] E_ADD_IMM = SR1_86 | SR2_IMM | G_ALU | LD_REG | LD_CC;
  localparam logic [24:0] E_AND_REG = SR1_86 | K_AND | G_ALU | LD_REG | LD_CC;
  localparam logic [24:0] E_NOT     = SR1_86 | K_NOT | G_ALU | LD_REG | LD_CC;
  localparam logic [24:0] E_BR_TKN  = A2_9 | P_ADDER | LD_PC;
  localparam logic [24:0] E_JMP     = SR1_86 | K_PASS | G_ALU | P_BUS | LD_PC;
  localparam logic [24:0] E_JSR1    = G_PC | DR_R7 | LD_REG;
  localparam logic [24:0] E_JSR2    = A2_11 | P_ADDER | LD_PC;
  localparam logic [24:0] E_ADDR    = SR1_86 | A1_SR1 | A2_6 | G_MARMUX | LD_MAR;
  localparam logic [24:0] E_STR2    = K_PASS | G_ALU | LD_MDR;
  localparam logic [24:0] E_LDR3    = G_MDR | LD_REG | LD_CC;

  logic       clk = 1'b0;
  logic       rst_a, rst_b, run_a, run_b;
  logic       cont, ir_5, ben;
  logic [3:0] opcode;
  logic [24:0] out_a, out_b;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lc3_control #(.MEM_WAIT(2)) u_dut_a (
    .i_clk(clk), .i_reset_n(rst_a), .i_run(run_a), .i_continue(cont),
    .i_opcode(opcode), .i_ir_5(ir_5), .i_ben(ben),
    .o_ld_mar(out_a[24]), .o_ld_mdr(out_a[23]), .o_ld_ir(out_a[22]), .o_ld_ben(out_a[21]),
    .o_ld_cc(out_a[20]), .o_ld_reg(out_a[19]), .o_ld_pc(out_a[18]), .o_ld_led(out_a[17]),
    .o_gate_pc(out_a[16]), .o_gate_mdr(out_a[15]), .o_gate_alu(out_a[14]), .o_gate_marmux(out_a[13]),
    .o_pcmux(out_a[12:11]), .o_addr2mux(out_a[10:9]), .o_addr1mux(out_a[8]), .o_sr1mux(out_a[7]),
    .o_sr2mux(out_a[6]), .o_drmux(out_a[5]), .o_aluk(out_a[4:3]), .o_mio_en(out_a[2]),
    .o_mem_rd(out_a[1]), .o_mem_wr(out_a[0])
  );

  lc3_control #(.MEM_WAIT(3)) u_dut_b (
    .i_clk(clk), .i_reset_n(rst_b), .i_run(run_b), .i_continue(cont),
    .i_opcode(opcode), .i_ir_5(ir_5), .i_ben(ben),
    .o_ld_mar(out_b[24]), .o_ld_mdr(out_b[23]), .o_ld_ir(out_b[22]), .o_ld_ben(out_b[21]),
    .o_ld_cc(out_b[20]), .o_ld_reg(out_b[19]), .o_ld_pc(out_b[18]), .o_ld_led(out_b[17]),
    .o_gate_pc(out_b[16]), .o_gate_mdr(out_b[15]), .o_gate_alu(out_b[14]), .o_gate_marmux(out_b[13]),
    .o_pcmux(out_b[12:11]), .o_addr2mux(out_b[10:9]), .o_addr1mux(out_b[8]), .o_sr1mux(out_b[7]),
    .o_sr2mux(out_b[6]), .o_drmux(out_b[5]), .o_aluk(out_b[4:3]), .o_mio_en(out_b[2]),
    .o_mem_rd(out_b[1]), .o_mem_wr(out_b[0])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input bit use_b, input logic [24:0] exp);
    logic [24:0] obs;
    obs = use_b ? out_b : out_a;
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts in FETCH1; ends in DECODE.
  task automatic fetch_decode(input string tag, input bit use_b, input int mw);
    for (int i = 0; i < mw; i++) begin
      tick();
      chk({tag, "_fetch2"}, use_b, (i == mw - 1) ? E_RD_LAST : E_RD);
    end
    tick(); chk({tag, "_fetch3"}, use_b, E_FETCH3);
    tick(); chk({tag, "_decode"}, use_b, LD_BEN);
  endtask

  task automatic back_to_fetch(input string tag, input bit use_b);
    tick(); chk({tag, "_fetch1"}, use_b, E_FETCH1);
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; run_a = 1'b0; run_b = 1'b0;
    cont = 1'b0; ir_5 = 1'b0; ben = 1'b0; opcode = 4'b0001;
    #12;
    chk("reset_outputs", 0, E_NONE);
    rst_a = 1'b1;
    tick(); tick();
    chk("halted_no_run", 0, E_NONE);

    run_a = 1'b1;
    tick(); chk("first_fetch1", 0, E_FETCH1);
    run_a = 1'b0;
    tick(); chk("pre_reset_fetch2", 0, E_RD);
    #3 rst_a = 1'b0;
    #1 chk("async_reset_mid_wait", 0, E_NONE);
    tick(); chk("reset_held", 0, E_NONE);
    rst_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("halted_after_reset", 0, E_NONE);
    end

    opcode = 4'b0001; ir_5 = 1'b1; run_a = 1'b1;
    tick(); chk("add_fetch1", 0, E_FETCH1);
    run_a = 1'b0;
    fetch_decode("add", 0, 2);
    tick(); chk("add_exec", 0, E_ADD_IMM);
    back_to_fetch("add", 0);

    opcode = 4'b0101; ir_5 = 1'b0;
    fetch_decode("and", 0, 2);
    tick(); chk("and_exec", 0, E_AND_REG);
    back_to_fetch("and", 0);

    opcode = 4'b1001;
    fetch_decode("not", 0, 2);
    tick(); chk("not_exec", 0, E_NOT);
    back_to_fetch("not", 0);

    opcode = 4'b0000; ben = 1'b0;
    fetch_decode("br_nt", 0, 2);
    tick(); chk("br_nt_br", 0, E_NONE);
    back_to_fetch("br_nt", 0);

    ben = 1'b1;
    fetch_decode("br_t", 0, 2);
    tick(); chk("br_t_br", 0, E_NONE);
    tick(); chk("br_t_taken", 0, E_BR_TKN);
    back_to_fetch("br_t", 0);
    ben = 1'b0;

    opcode = 4'b1100;
    fetch_decode("jmp", 0, 2);
    tick(); chk("jmp_exec", 0, E_JMP);
    back_to_fetch("jmp", 0);

    opcode = 4'b0100;
    fetch_decode("jsr", 0, 2);
    tick(); chk("jsr1", 0, E_JSR1);
    tick(); chk("jsr2", 0, E_JSR2);
    back_to_fetch("jsr", 0);

    opcode = 4'b0111;
    fetch_decode("str", 0, 2);
    tick(); chk("str1", 0, E_ADDR);
    tick(); chk("str2", 0, E_STR2);
    tick(); chk("str3_a", 0, MWR);
    tick(); chk("str3_b", 0, MWR);
    back_to_fetch("str", 0);

    opcode = 4'b1101; cont = 1'b0;
    fetch_decode("pause", 0, 2);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("pause1_hold", 0, LD_LED);
    end
    cont = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(); chk("pause2_hold", 0, E_NONE);
    end
    cont = 1'b0;
    back_to_fetch("pause", 0);

    cont = 1'b1;
    fetch_decode("pause_early", 0, 2);
    tick(); chk("pause1_single", 0, LD_LED);
    tick(); chk("pause2_entry", 0, E_NONE);
    tick(); chk("pause2_stay", 0, E_NONE);
    cont = 1'b0;
    back_to_fetch("pause_early", 0);

    opcode = 4'b1111;
    fetch_decode("illegal", 0, 2);
    back_to_fetch("illegal", 0);

    rst_a = 1'b0;
    rst_b = 1'b1;
    opcode = 4'b0110;
    tick(); chk("b_halted", 1, E_NONE);
    run_b = 1'b1;
    tick(); chk("ldr_fetch1", 1, E_FETCH1);
    run_b = 1'b0;
    fetch_decode("ldr", 1, 3);
    tick(); chk("ldr1", 1, E_ADDR);
    tick(); chk("ldr2_a", 1, E_RD);
    tick(); chk("ldr2_b", 1, E_RD);
    tick(); chk("ldr2_c", 1, E_RD_LAST);
    tick(); chk("ldr3", 1, E_LDR3);
    back_to_fetch("ldr", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
